// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: machine word, fetch FSM states and the IF/ID register layout.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam word_t NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    HOLD     = 2'd1,
    REDIRECT = 2'd2,
    HALTED   = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic  valid;
    word_t instr;
    word_t pc4;
  } ifid_t;

  // Wraps modulo 2^32 so the last word of the address space returns 0.
  function automatic word_t pc_plus4(word_t pc);
    return pc + word_t'(4);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: PC unit, instruction memory, hazard controls and IF/ID outputs.
interface fetch_unit_if #(
  parameter int WORD_W = 32
);

  logic              pc_enable;
  logic [WORD_W-1:0] pc;
  logic              imemREN;
  logic [WORD_W-1:0] imemaddr;
  logic              ihit;
  logic [WORD_W-1:0] iload;
  logic              stall;
  logic              flush;
  logic              halt;
  logic              ifid_valid;
  logic [WORD_W-1:0] ifid_instr;
  logic [WORD_W-1:0] ifid_pc4;
  logic              skid_full;

  // master: the fetch unit, which issues memory reads and owns IF/ID
  modport master (
    input  pc, ihit, iload, stall, flush, halt,
    output pc_enable, imemREN, imemaddr,
    output ifid_valid, ifid_instr, ifid_pc4, skid_full
  );

  // slave: PC unit, instruction memory and hazard logic around it
  modport slave (
    output pc, ihit, iload, stall, flush, halt,
    input  pc_enable, imemREN, imemaddr,
    input  ifid_valid, ifid_instr, ifid_pc4, skid_full
  );

endinterface

// File: rtl/ifid_skid.sv
// One-entry skid register holding an instruction fetched while decode was stalled.
module ifid_skid
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  load_i,
  input  logic  drain_i,
  input  logic  clear_i,
  input  word_t instr_i,
  input  word_t pc4_i,
  output logic  full_o,
  output word_t instr_o,
  output word_t pc4_o
);

  logic  full_q, full_d;
  word_t instr_q, instr_d;
  word_t pc4_q, pc4_d;

  // clear (flush/halt) wins over a same-cycle load or drain
  always_comb begin
    full_d  = full_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (clear_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      full_d  = 1'b1;
      instr_d = instr_i;
      pc4_d   = pc4_i;
    end else if (drain_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      full_q  <= 1'b0;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
    end else begin
      full_q  <= full_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign full_o  = full_q;
  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: reads imem at pc, fills IF/ID, absorbs stalls via a skid entry.
//
// state    | meaning
// FETCH    | imem read active, capture on ihit
// HOLD     | one instruction parked in skid, waiting for stall to drop
// REDIRECT | one idle cycle after flush so imem sees the new pc
// HALTED   | fetching stopped until reset
module fetch_unit #(
  parameter int                WORD_W    = 32,
  parameter logic [WORD_W-1:0] NOP_INSTR = cpu_types_pkg::NOP_INSTR
) (
  input logic         CLK,
  input logic         RST,
  fetch_unit_if.master bus
);

  import cpu_types_pkg::*;

  fetch_state_t state_q, state_d;
  ifid_t        ifid_q, ifid_d;
  ifid_t        bubble;
  word_t        pc4;
  logic         pc_en;
  logic         skid_load, skid_drain, skid_clear, skid_full;
  word_t        skid_instr, skid_pc4;

  assign pc4    = pc_plus4(bus.pc);
  assign bubble = '{valid: 1'b0, instr: NOP_INSTR, pc4: ifid_q.pc4};

  always_comb begin
    state_d    = state_q;
    ifid_d     = ifid_q;
    pc_en      = 1'b0;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    skid_clear = 1'b0;
    if (state_q != HALTED) begin
      if (bus.halt) begin
        state_d    = HALTED;
        ifid_d     = bubble;
        skid_clear = 1'b1;
      end else if (bus.flush) begin
        // pc_enable lets the PC unit load the redirect target this cycle
        state_d    = REDIRECT;
        ifid_d     = bubble;
        skid_clear = 1'b1;
        pc_en      = 1'b1;
      end else begin
        unique case (state_q)
          FETCH: begin
            if (bus.ihit && !bus.stall) begin
              ifid_d = '{valid: 1'b1, instr: bus.iload, pc4: pc4};
              pc_en  = 1'b1;
            end else if (bus.ihit) begin
              skid_load = 1'b1;
              pc_en     = 1'b1;
              state_d   = HOLD;
            end else if (!bus.stall) begin
              ifid_d = bubble;
            end
          end
          HOLD: begin
            // PC already advanced when the skid entry was captured
            if (!bus.stall) begin
              ifid_d     = '{valid: 1'b1, instr: skid_instr, pc4: skid_pc4};
              skid_drain = 1'b1;
              state_d    = FETCH;
            end
          end
          REDIRECT: state_d = FETCH;
          default:  state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= FETCH;
      ifid_q  <= '{valid: 1'b0, instr: NOP_INSTR, pc4: '0};
    end else begin
      state_q <= state_d;
      ifid_q  <= ifid_d;
    end
  end

  ifid_skid u_skid (
    .CLK     (CLK),
    .RST     (RST),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .clear_i (skid_clear),
    .instr_i (bus.iload),
    .pc4_i   (pc4),
    .full_o  (skid_full),
    .instr_o (skid_instr),
    .pc4_o   (skid_pc4)
  );

  assign bus.pc_enable  = pc_en && !RST;
  assign bus.imemREN    = (state_q == FETCH) && !RST;
  assign bus.imemaddr   = bus.pc;
  assign bus.ifid_valid = ifid_q.valid;
  assign bus.ifid_instr = ifid_q.instr;
  assign bus.ifid_pc4   = ifid_q.pc4;
  assign bus.skid_full  = skid_full;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit against a flag-based behavioural model.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if #(.WORD_W(32)) bus ();

  fetch_unit #(.WORD_W(32), .NOP_INSTR(32'h0000_0000)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.master)
  );

  localparam logic [31:0] NOP = 32'h0000_0000;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model: IF/ID contents, skid contents and three mode flags
  logic        m_halted, m_redirect, m_skid_full;
  logic [31:0] m_skid_instr, m_skid_pc4;
  logic        m_valid;
  logic [31:0] m_instr, m_pc4;

  logic [31:0] pc_r;
  logic        prev_pcen;
  logic [31:0] prev_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_halted    = 1'b0;
    m_redirect  = 1'b0;
    m_skid_full = 1'b0;
    m_valid     = 1'b0;
    m_instr     = NOP;
    m_pc4       = 32'h0;
    prev_pcen   = 1'b0;
    prev_pc     = 32'h0;
  endtask

  task automatic do_reset();
    bus.ihit  = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.halt  = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_valid", {31'b0, bus.ifid_valid}, 32'h0);
    chk("rst_skid", {31'b0, bus.skid_full}, 32'h0);
    chk("rst_instr", bus.ifid_instr, NOP);
    chk("rst_pc4", bus.ifid_pc4, 32'h0);
    chk("rst_pcen", {31'b0, bus.pc_enable}, 32'h0);
    chk("rst_ren", {31'b0, bus.imemREN}, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold_ren", {31'b0, bus.imemREN}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.ihit = 1'b0;
    model_reset();
  endtask

  // one cycle: drive at negedge, check combinational outputs, clock, check registers
  task automatic step(input logic ihit, input logic [31:0] iload, input logic stall,
                      input logic flush, input logic halt);
    logic e_pcen, e_ren, inv;
    logic [31:0] pc4;
    bus.pc    = pc_r;
    bus.ihit  = ihit;
    bus.iload = iload;
    bus.stall = stall;
    bus.flush = flush;
    bus.halt  = halt;
    pc4 = pc_r + 32'd4;
    #1;
    e_ren = !m_halted && !m_redirect && !m_skid_full;
    if (m_halted || halt)             e_pcen = 1'b0;
    else if (flush)                   e_pcen = 1'b1;
    else if (m_redirect || m_skid_full) e_pcen = 1'b0;
    else                              e_pcen = ihit;
    chk("pc_enable", {31'b0, bus.pc_enable}, {31'b0, e_pcen});
    chk("imemREN", {31'b0, bus.imemREN}, {31'b0, e_ren});
    chk("imemaddr", bus.imemaddr, pc_r);
    inv = bus.pc_enable && prev_pcen && (pc_r == prev_pc) && !flush;
    chk("pcen_twice", {31'b0, inv}, 32'h0);
    prev_pcen = bus.pc_enable;
    prev_pc   = pc_r;
    @(posedge clk);
    if (m_halted) begin
    end else if (halt) begin
      m_halted = 1'b1; m_valid = 1'b0; m_instr = NOP; m_skid_full = 1'b0;
    end else if (flush) begin
      m_redirect = 1'b1; m_valid = 1'b0; m_instr = NOP; m_skid_full = 1'b0;
    end else if (m_redirect) begin
      m_redirect = 1'b0;
    end else if (m_skid_full) begin
      if (!stall) begin
        m_valid = 1'b1; m_instr = m_skid_instr; m_pc4 = m_skid_pc4; m_skid_full = 1'b0;
      end
    end else if (ihit && !stall) begin
      m_valid = 1'b1; m_instr = iload; m_pc4 = pc4;
    end else if (ihit) begin
      m_skid_full = 1'b1; m_skid_instr = iload; m_skid_pc4 = pc4;
    end else if (!stall) begin
      m_valid = 1'b0; m_instr = NOP;
    end
    #1;
    chk("ifid_valid", {31'b0, bus.ifid_valid}, {31'b0, m_valid});
    chk("ifid_instr", bus.ifid_instr, m_instr);
    chk("ifid_pc4", bus.ifid_pc4, m_pc4);
    chk("skid_full", {31'b0, bus.skid_full}, {31'b0, m_skid_full});
    if (e_pcen) pc_r = flush ? ($urandom() & 32'hFFFF_FFFC) : pc_r + 32'd4;
    @(negedge clk);
  endtask

  initial begin
    bus.pc = '0; bus.ihit = 1'b0; bus.iload = '0;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.halt = 1'b0;
    pc_r = 32'h0;
    model_reset();
    @(negedge clk);
    do_reset();

    // back-to-back hits from pc 0
    pc_r = 32'h0;
    step(1'b1, 32'h2001_0005, 1'b0, 1'b0, 1'b0);
    chk("b2b_pc4_a", bus.ifid_pc4, 32'h4);
    step(1'b1, 32'h2002_0007, 1'b0, 1'b0, 1'b0);
    chk("b2b_pc4_b", bus.ifid_pc4, 32'h8);
    chk("b2b_instr", bus.ifid_instr, 32'h2002_0007);

    // hit under stall parks in skid, drains after release
    pc_r = 32'h10;
    step(1'b1, 32'h8C22_0000, 1'b1, 1'b0, 1'b0);
    chk("skid_cap", {31'b0, bus.skid_full}, 32'h1);
    chk("skid_ifid_kept", bus.ifid_instr, 32'h2002_0007);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("drain_instr", bus.ifid_instr, 32'h8C22_0000);
    chk("drain_pc4", bus.ifid_pc4, 32'h14);
    chk("drain_skid", {31'b0, bus.skid_full}, 32'h0);

    // flush with a same-cycle hit
    pc_r = 32'h24;
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
    chk("flush_instr", bus.ifid_instr, NOP);
    step(1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h2222_2222, 1'b0, 1'b0, 1'b0);

    // flush in HOLD overrides the stall
    step(1'b1, 32'h3333_3333, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("hold_flush_skid", {31'b0, bus.skid_full}, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h4444_4444, 1'b0, 1'b0, 1'b0);

    // halt with a same-cycle hit, then sticky
    step(1'b1, 32'h5555_5555, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++)
      step(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'b0);
    chk("halted_ren", {31'b0, bus.imemREN}, 32'h0);
    do_reset();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // pc+4 wraps at the top of the address space
    pc_r = 32'hFFFF_FFFC;
    step(1'b1, 32'h6666_6666, 1'b0, 1'b0, 1'b0);
    chk("wrap_pc4", bus.ifid_pc4, 32'h0);

    // asynchronous reset while in HOLD
    step(1'b1, 32'h7777_7777, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_skid", {31'b0, bus.skid_full}, 32'h1);
    #2;
    do_reset();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0 || (m_halted && $urandom_range(0, 7) == 0)) begin
        #2;
        do_reset();
      end else begin
        step(1'($urandom_range(0, 2) != 0), $urandom(), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 59) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage; consumer side of the PC interface.
- Presents the current PC to instruction memory and waits for ihit. Latches the returned instruction and PC+4 into the IF/ID register, then pulses pc_enable so the PC unit advances.
- Absorbs hazard stalls through a one-entry skid buffer. Squashes on branch/jump redirect and stops cleanly on halt.

Parameters:
- WORD_W, 32, width of address, instruction and PC+4 words.
- NOP_INSTR, 32'h00000000, value loaded into ifid_instr on reset, flush or bubble.

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  reset: one clock; reset is asynchronous and active-high
- pc  in  WORD_W  current PC from PC unit
- pc_enable  out  1  PC-advance strobe to PC unit (PC loads its next-PC when high)
- imemREN  out  1  instruction memory read enable
- imemaddr  out  WORD_W  instruction memory address
- ihit  in  1  instruction memory data valid this cycle
- iload  in  WORD_W  instruction memory read data
- stall  in  1  hazard unit: hold IF/ID contents
- flush  in  1  branch/jump resolved taken: squash IF/ID, redirect PC
- halt  in  1  halt decoded; stop fetching
- ifid_valid  out  1  IF/ID holds a real instruction
- ifid_instr  out  WORD_W  IF/ID instruction
- ifid_pc4  out  WORD_W  IF/ID PC+4 (feeds branch_pc4)
- skid_full  out  1  debug/status: skid buffer occupied

Behaviour:
- Reset (RST high, async): state=FETCH, ifid_instr=NOP_INSTR, ifid_valid=0, ifid_pc4=0, skid empty. pc_enable=0, imemREN=0 while RST high.
- imemaddr = pc at all times. imemREN = 1 in FETCH only.
- pc_enable and imemREN are combinational from state and inputs. All ifid_* and skid outputs are registered.
- Input priority each cycle: halt > flush > stall > ihit.
- FETCH state:
  - ihit & !stall & !flush: ifid <= {iload, pc+4, valid=1}; pc_enable=1; stay in FETCH. Back-to-back hits give one instruction per cycle.
  - ihit & stall & !flush: skid <= {iload, pc+4}; pc_enable=1; go to HOLD. IF/ID is unchanged.
  - !ihit & !stall & !flush: ifid <= bubble (NOP_INSTR, valid=0); pc_enable=0.
  - !ihit & stall: IF/ID held; pc_enable=0.
- HOLD state:
  - imemREN=0.
  - stall: hold everything; pc_enable=0.
  - !stall: ifid <= skid (valid=1); skid cleared; go to FETCH; pc_enable=0 (PC already advanced on capture).
- flush (any state except HALTED):
  - ifid <= NOP_INSTR, valid=0; skid cleared; pc_enable=1 that cycle so the PC loads the redirect target.
  - Any ihit data in the same cycle is discarded.
  - Go to REDIRECT.
  - flush overrides stall.
- REDIRECT state: imemREN=0 for exactly one cycle so the cache sees the new address; pc_enable=0; then go to FETCH. A flush arriving in REDIRECT re-enters REDIRECT.
- halt: from any state go to HALTED. In HALTED, imemREN=0 and pc_enable=0 permanently. IF/ID gets a bubble the cycle halt is seen; skid is discarded. HALTED is sticky until RST.
- Simultaneous ihit & halt: data discarded, no pc_enable.
- Reset mid-HOLD or mid-REDIRECT: state and registers return to their reset values immediately; no residual pulse.
- ifid_pc4 = pc + 4, computed modulo 2^WORD_W: 32'hFFFFFFFC + 4 wraps to 0.
- Invariant: pc_enable is never high for two cycles on the same pc value unless flush is asserted.

Decomposition:
- Shared package cpu_types_pkg gets: word_t (already present); a new enum fetch_state_t {FETCH, HOLD, REDIRECT, HALTED}; constant NOP_INSTR; struct ifid_t {valid, instr, pc4}.
- Sub-module ifid_skid: one-entry skid register, with load, drain and clear inputs and a full output. The FSM plus datapath stays in fetch_unit.

Test Plan:
- Reset then pc=0x00000000, ihit=1 every cycle with iload=0x20010005, 0x20020007 -> pc_enable high each cycle; ifid_pc4 0x4 then 0x8; ifid_valid=1 from the cycle after the first hit.
- ihit=1 with stall=1 at pc=0x10, iload=0x8C220000 -> pc_enable=1 once; skid_full=1; IF/ID unchanged. Release stall after 3 cycles -> ifid_instr=0x8C220000, ifid_pc4=0x14; skid_full=0.
- flush=1 together with ihit=1 at pc=0x24 -> IF/ID=NOP, valid=0; pc_enable=1; iload discarded; imemREN=0 next cycle; FETCH resumes the following cycle.
- flush=1 while in HOLD with stall=1 -> skid_full=0; ifid_valid=0; REDIRECT is entered despite the stall.
- halt=1 together with ihit=1 -> no pc_enable; imemREN stays 0 for 10+ cycles. RST pulse -> FETCH, imemREN=1 after RST falls.
- pc=0xFFFFFFFC, ihit=1 -> ifid_pc4=0x00000000. RST asserted mid-HOLD -> ifid_valid=0, skid_full=0 asynchronously, before the next clock edge.
